// File: rtl/gate_array_pipe.sv
// Registered WIDTH-bit two-operand gate array with a valid/ready handshake and a two-entry skid buffer.
// Optional feature: define GATE_PIPE_PARITY_EN to add the out_parity port (^y) and its storage.
module gate_array_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_all,
`ifdef GATE_PIPE_PARITY_EN
    output logic             y_any,
    output logic             out_parity
`else
    output logic             y_any
`endif
);

`ifdef GATE_PIPE_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    // Entry layout, LSB first: result, all-ones flag, any-one flag, then parity when enabled.
    localparam int ENTRY_W = WIDTH + 2 + PAR_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    function automatic logic parity_f(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    state_t             state_r;
    logic [ENTRY_W-1:0] main_r;
    logic [ENTRY_W-1:0] skid_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   res_s;
    logic [ENTRY_W-1:0] entry_s;
    logic               in_xfer_s;
    logic               out_xfer_s;

    assign in_xfer_s  = in_valid & in_ready_r;
    assign out_xfer_s = out_valid_r & out_ready;

    // Bitwise operation selected by op.
    always_comb begin
        res_s = '0;
        case (op)
            3'd0:    res_s = a & b;
            3'd1:    res_s = a | b;
            3'd2:    res_s = a ^ b;
            3'd3:    res_s = ~(a & b);
            3'd4:    res_s = ~(a | b);
            3'd5:    res_s = ~(a ^ b);
            3'd6:    res_s = a & ~b;
            3'd7:    res_s = a;
            default: res_s = a;
        endcase
    end

    // Pack the result and its reduction flags into one stage entry.
    always_comb begin
        entry_s = '0;
`ifdef GATE_PIPE_PARITY_EN
        entry_s = {parity_f(res_s), |res_s, &res_s, res_s};
`else
        entry_s = {|res_s, &res_s, res_s};
`endif
    end

    // Skid FSM: main entry drives the outputs, skid holds the second accepted result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            main_r      <= '0;
            skid_r      <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        main_r      <= entry_s;
                        state_r     <= ST_ONE;
                        out_valid_r <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        main_r <= entry_s;
                    end else if (in_xfer_s) begin
                        skid_r     <= entry_s;
                        state_r    <= ST_FULL;
                        in_ready_r <= 1'b0;
                    end else if (out_xfer_s) begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (out_xfer_s) begin
                        main_r     <= skid_r;
                        state_r    <= ST_ONE;
                        in_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign y          = main_r[WIDTH-1:0];
    assign y_all      = main_r[WIDTH];
    assign y_any      = main_r[WIDTH+1];
`ifdef GATE_PIPE_PARITY_EN
    assign out_parity = main_r[WIDTH+2];
`endif

endmodule

// File: tb/tb_gate_array_pipe.sv
// Self-checking bench for gate_array_pipe: a queue model of accepted results checked every cycle,
// plus directed vectors with literal expectations. Honours GATE_PIPE_PARITY_EN when defined.
module tb_gate_array_pipe;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             y_all;
    logic             y_any;
`ifdef GATE_PIPE_PARITY_EN
    logic             out_parity;
`endif

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] q[$];
    logic [7:0] exp_ops [8] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hC5, 8'hC5};

    gate_array_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_all     (y_all),
`ifdef GATE_PIPE_PARITY_EN
        .y_any     (y_any),
        .out_parity(out_parity)
`else
        .y_any     (y_any)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_gate(input logic [2:0] o,
                                                    input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] z);
        logic [WIDTH-1:0] r;
        case (o)
            3'd0:    r = x & z;
            3'd1:    r = x | z;
            3'd2:    r = x ^ z;
            3'd3:    r = ~(x & z);
            3'd4:    r = ~(x | z);
            3'd5:    r = ~(x ^ z);
            3'd6:    r = x & ~z;
            default: r = x;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare process: outputs against the ordered queue of accepted results, then advance the model.
    always @(negedge clk) begin : cmp
        bit ox;
        bit ix;
        if (!rst_n) begin
            q.delete();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_y", 32'(y), 32'd0);
            chk("rst_flags", {30'd0, y_all, y_any}, 32'd0);
`ifdef GATE_PIPE_PARITY_EN
            chk("rst_parity", 32'(out_parity), 32'd0);
`endif
        end else begin
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0) begin
                chk("y", 32'(y), 32'(q[0]));
                chk("y_all", 32'(y_all), 32'(q[0] == {WIDTH{1'b1}}));
                chk("y_any", 32'(y_any), 32'(q[0] != '0));
`ifdef GATE_PIPE_PARITY_EN
                chk("out_parity", 32'(out_parity), 32'($countones(q[0]) % 2));
`endif
            end
            ox = (q.size() > 0) && out_ready;
            ix = in_valid && (q.size() < 2);
            if (ox) q.delete(0);
            if (ix) q.push_back(model_gate(op, a, b));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; a = 8'hC5; b = 8'h3A; op = 3'd0; out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_hold_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0; rst_n = 1'b1;
        repeat (3) tick();
        chk("no_spurious", 32'(out_valid), 32'd0);

        // All eight ops, back-to-back, result one cycle after acceptance.
        for (int k = 0; k < 8; k++) begin
            op = 3'(k); a = 8'hC5; b = 8'h3A; in_valid = 1'b1;
            tick();
            chk($sformatf("op%0d_y", k), 32'(y), 32'(exp_ops[k]));
            chk($sformatf("op%0d_valid", k), 32'(out_valid), 32'd1);
            if (k == 0) chk("op0_any_all", {30'd0, y_any, y_all}, 32'd0);
            if (k == 1) chk("op1_all", 32'(y_all), 32'd1);
        end
        in_valid = 1'b0;
        repeat (2) tick();

        // Backpressure: two accepted, third stalls, then drained in order.
        out_ready = 1'b0; op = 3'd2;
        a = 8'h0F; b = 8'hF0; in_valid = 1'b1;
        tick();
        a = 8'hFF; b = 8'h01;
        tick();
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_y_first", 32'(y), 32'hFF);
        a = 8'hAA; b = 8'hAA;
        tick();
        chk("bp_stall_y", 32'(y), 32'hFF);
        chk("bp_still_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_y_second", 32'(y), 32'hFE);
        chk("bp_in_ready_back", 32'(in_ready), 32'd1);
        tick();
        chk("bp_y_third", 32'(y), 32'h00);
        in_valid = 1'b0;
        repeat (2) tick();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Streaming with simultaneous in/out transfers.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; a = 8'(i * 17); b = ~8'(i * 3); op = 3'(i % 8);
            tick();
            chk("stream_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        repeat (2) tick();

        // Asynchronous reset while FULL.
        out_ready = 1'b0; op = 3'd1; a = 8'h12; b = 8'h34; in_valid = 1'b1;
        tick();
        op = 3'd2; a = 8'h56; b = 8'h78;
        tick();
        chk("full_before_rst", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_ready", 32'(in_ready), 32'd1);
        chk("async_rst_y", 32'(y), 32'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1; op = 3'd1; a = 8'hF0; b = 8'h0F; in_valid = 1'b1;
        tick();
        chk("post_rst_y", 32'(y), 32'hFF);
        in_valid = 1'b0;
        tick();
        chk("post_rst_only_one", 32'(out_valid), 32'd0);

        // Parity vector.
        op = 3'd1; a = 8'h07; b = 8'h00; in_valid = 1'b1;
        tick();
        chk("par_y", 32'(y), 32'h07);
`ifdef GATE_PIPE_PARITY_EN
        chk("par_bit", 32'(out_parity), 32'd1);
`endif
        in_valid = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
